// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared op codes and FSM states for the HI/LO multiply/divide unit
package mdu_ctrl_pkg;
   localparam int MDU_OP_WD = 3;
   typedef enum logic [MDU_OP_WD-1:0] {
      MDU_NONE  = 3'd0,
      MDU_MULT  = 3'd1,
      MDU_MULTU = 3'd2,
      MDU_DIV   = 3'd3,
      MDU_DIVU  = 3'd4,
      MDU_MTHI  = 3'd5,
      MDU_MTLO  = 3'd6
   } mdu_op_e;
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } mdu_state_e;
endpackage

// File: rtl/mdu_iter.sv
// mdu_iter: iteration registers and one-step shift-add multiply / restoring divide
module mdu_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             step,
   input  logic             is_div,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   // hi_q: product high half / remainder; lo_q: multiplier then product low half / dividend then quotient
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, b_q, rem_sub;
   logic [WIDTH:0]   sum, rem_sh;
   logic             ge;
   // one iteration: quotient bits shift into lo_q as dividend bits leave it
   always_comb begin
      sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
      rem_sh  = {hi_q, lo_q[WIDTH-1]};
      rem_sub = rem_sh[WIDTH-1:0] - b_q;
      ge      = rem_sh >= {1'b0, b_q};
      hi_d    = is_div ? (ge ? rem_sub : rem_sh[WIDTH-1:0]) : sum[WIDTH:1];
      lo_d    = is_div ? {lo_q[WIDTH-2:0], ge} : {sum[0], lo_q[WIDTH-1:1]};
   end
   // load operands on start, advance one step per CALC cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         hi_q <= '0;
         lo_q <= '0;
         b_q  <= '0;
      end else if (load) begin
         hi_q <= '0;
         lo_q <= a;
         b_q  <= b;
      end else if (step) begin
         hi_q <= hi_d;
         lo_q <= lo_d;
      end
   end
   assign hi = hi_q;
   assign lo = lo_q;
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide sequencer owning HI/LO and the EX stall request
module mdu_ctrl
   import mdu_ctrl_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 ex_stall,
   input  logic [MDU_OP_WD-1:0] mdu_op,
   input  logic [WIDTH-1:0]     src_a,
   input  logic [WIDTH-1:0]     src_b,
   output logic                 stallreq,
   output logic                 busy,
   output logic [WIDTH-1:0]     hi_rdata,
   output logic [WIDTH-1:0]     lo_rdata
);
   localparam int CNT_WD = $clog2(WIDTH);
   localparam logic [WIDTH-1:0]   ONE  = 1;
   localparam logic [2*WIDTH-1:0] ONE2 = 1;
   mdu_state_e       state_q, state_d;
   logic [CNT_WD-1:0] cnt_q, cnt_d;
   logic             neg_quo_q, neg_rem_q, is_div_q, first_q;
   logic [WIDTH-1:0] hi_q, lo_q, it_hi, it_lo, mag_a, mag_b, quo_fix, rem_fix;
   logic [2*WIDTH-1:0] prod_fix;
   logic             is_div_op, is_md, is_sgn, start, last;
   // decode, operand magnitudes, result sign fixup, next state and stall outputs
   always_comb begin
      is_div_op = mdu_op == MDU_DIV || mdu_op == MDU_DIVU;
      is_md     = mdu_op == MDU_MULT || mdu_op == MDU_MULTU || is_div_op;
      is_sgn    = mdu_op == MDU_MULT || mdu_op == MDU_DIV;
      start     = is_md && state_q == S_IDLE && !(is_div_op && src_b == '0);
      mag_a     = (is_sgn && src_a[WIDTH-1]) ? ~src_a + ONE : src_a;
      mag_b     = (is_sgn && src_b[WIDTH-1]) ? ~src_b + ONE : src_b;
      last      = cnt_q == CNT_WD'(WIDTH - 1);
      prod_fix  = neg_quo_q ? ~{it_hi, it_lo} + ONE2 : {it_hi, it_lo};
      quo_fix   = neg_quo_q ? ~it_lo + ONE : it_lo;
      rem_fix   = neg_rem_q ? ~it_hi + ONE : it_hi;
      state_d   = state_q;
      cnt_d     = cnt_q;
      case (state_q)
         S_IDLE: begin
            state_d = start ? S_CALC : S_IDLE;
            cnt_d   = '0;
         end
         S_CALC: begin
            state_d = last ? S_DONE : S_CALC;
            cnt_d   = cnt_q + 1'b1;
         end
         S_DONE:  state_d = ex_stall ? S_DONE : S_IDLE;
         default: state_d = S_IDLE;
      endcase
      stallreq  = start || state_q == S_CALC;
      busy      = state_q != S_IDLE;
   end
   // state, counter, sign flags and HI/LO; results commit once, at the end of the first DONE cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         is_div_q  <= 1'b0;
         first_q   <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         first_q <= state_q == S_CALC && last;
         if (start) begin
            neg_quo_q <= is_sgn && (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
            neg_rem_q <= is_sgn && src_a[WIDTH-1];
            is_div_q  <= is_div_op;
         end
         if (first_q) begin
            if (is_div_q) begin
               lo_q <= quo_fix;
               hi_q <= rem_fix;
            end else
               {hi_q, lo_q} <= prod_fix;
         end else if (state_q == S_IDLE && !ex_stall) begin
            if (mdu_op == MDU_MTHI) hi_q <= src_a;
            if (mdu_op == MDU_MTLO) lo_q <= src_a;
         end
      end
   end
   mdu_iter #(.WIDTH(WIDTH)) u_iter (
      .clk   (clk),
      .rst   (rst),
      .load  (start),
      .step  (state_q == S_CALC),
      .is_div(is_div_q),
      .a     (mag_a),
      .b     (mag_b),
      .hi    (it_hi),
      .lo    (it_lo)
   );
   assign hi_rdata = hi_q;
   assign lo_rdata = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: directed vectors for the multiply/divide sequencer
module tb_mdu_ctrl;
   import mdu_ctrl_pkg::*;
   logic        clk = 1'b0;
   logic        rst, ex_stall, stallreq, busy;
   logic [2:0]  mdu_op;
   logic [31:0] src_a, src_b, hi_rdata, lo_rdata;
   int          checks = 0, errors = 0, n;
   mdu_ctrl dut (
      .clk     (clk),
      .rst     (rst),
      .ex_stall(ex_stall),
      .mdu_op  (mdu_op),
      .src_a   (src_a),
      .src_b   (src_b),
      .stallreq(stallreq),
      .busy    (busy),
      .hi_rdata(hi_rdata),
      .lo_rdata(lo_rdata)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask
   // called at a negedge; returns the number of cycles stallreq stayed high, leaves FSM in first DONE cycle
   task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, output int cnt);
      cnt = 0;
      mdu_op = op;
      src_a = a;
      src_b = b;
      for (int i = 0; i < 100; i++) begin
         #1;
         if (!stallreq) break;
         cnt++;
         @(negedge clk);
      end
      mdu_op = MDU_NONE;
   endtask
   task automatic wait_idle();
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!busy) break;
      end
      check("idle", {63'd0, busy}, 64'd0);
   endtask
   task automatic mt(input logic [2:0] op, input logic [31:0] a);
      mdu_op = op;
      src_a = a;
      @(negedge clk);
      mdu_op = MDU_NONE;
   endtask
   initial begin
      rst = 1'b1;
      ex_stall = 1'b0;
      mdu_op = MDU_NONE;
      src_a = '0;
      src_b = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_stall", {63'd0, stallreq}, 64'd0);
      check("rst_hilo", {hi_rdata, lo_rdata}, 64'd0);
      rst = 1'b0;
      @(negedge clk);
      do_op(MDU_MULT, 32'hFFFF_FFFE, 32'd3, n);
      check("mult_stall", 64'(n), 64'd33);
      wait_idle();
      check("mult_hilo", {hi_rdata, lo_rdata}, 64'hFFFF_FFFF_FFFF_FFFA);
      do_op(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, n);
      check("multu_stall", 64'(n), 64'd33);
      wait_idle();
      check("multu_hilo", {hi_rdata, lo_rdata}, 64'hFFFF_FFFE_0000_0001);
      do_op(MDU_DIVU, 32'd7, 32'd2, n);
      check("divu_stall", 64'(n), 64'd33);
      wait_idle();
      check("divu_hilo", {hi_rdata, lo_rdata}, 64'h0000_0001_0000_0003);
      do_op(MDU_DIV, 32'hFFFF_FFF9, 32'd2, n);
      wait_idle();
      check("div_neg_hilo", {hi_rdata, lo_rdata}, 64'hFFFF_FFFF_FFFF_FFFD);
      do_op(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, n);
      wait_idle();
      check("div_ovf_hilo", {hi_rdata, lo_rdata}, 64'h0000_0000_8000_0000);
      mt(MDU_MTHI, 32'hAA);
      check("mthi", 64'(hi_rdata), 64'hAA);
      mt(MDU_MTLO, 32'hBB);
      check("mtlo", 64'(lo_rdata), 64'hBB);
      mdu_op = MDU_DIV;
      src_a = 32'd5;
      src_b = 32'd0;
      #1;
      check("div0_stall", {63'd0, stallreq}, 64'd0);
      @(negedge clk);
      check("div0_busy", {63'd0, busy}, 64'd0);
      mdu_op = MDU_NONE;
      check("div0_hilo", {hi_rdata, lo_rdata}, 64'h0000_00AA_0000_00BB);
      do_op(MDU_MULT, 32'd3, 32'd5, n);
      check("hold_stall", 64'(n), 64'd33);
      ex_stall = 1'b1;
      mdu_op = MDU_MULT;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_busy", {63'd0, busy}, 64'd1);
         check("hold_noreq", {63'd0, stallreq}, 64'd0);
         check("hold_hilo", {hi_rdata, lo_rdata}, 64'd15);
      end
      ex_stall = 1'b0;
      mdu_op = MDU_NONE;
      @(negedge clk);
      check("hold_release", {63'd0, busy}, 64'd0);
      check("hold_final", {hi_rdata, lo_rdata}, 64'd15);
      mt(MDU_MTHI, 32'h1234);
      check("mfhi_next", 64'(hi_rdata), 64'h1234);
      check("mflo_keep", 64'(lo_rdata), 64'd15);
      mdu_op = MDU_MULT;
      src_a = 32'd3;
      src_b = 32'd5;
      repeat (11) @(negedge clk);
      check("calc_busy", {63'd0, busy}, 64'd1);
      check("calc_req", {63'd0, stallreq}, 64'd1);
      rst = 1'b1;
      mdu_op = MDU_NONE;
      @(negedge clk);
      rst = 1'b0;
      check("rst_calc_busy", {63'd0, busy}, 64'd0);
      check("rst_calc_req", {63'd0, stallreq}, 64'd0);
      check("rst_calc_hilo", {hi_rdata, lo_rdata}, 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
